// File: rtl/core7_cpu_3_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into a 15-atom DCT frame and hands it downstream,
// with an end-of-test flush that closes the block until the next reset.
module core7_cpu_3_nios2_oci_dct_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [1:0]  atom_data,
    output logic        atom_ready,
    input  logic        end_req,
    input  logic        frame_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        frame_valid,
    output logic        test_ending,
    output logic        test_has_ended,
    output logic [7:0]  dropped_atoms
);

    localparam int unsigned ATOM_W    = 2;
    localparam int unsigned MAX_ATOMS = 15;
    localparam int unsigned BUF_W     = ATOM_W * MAX_ATOMS;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DROP_W    = 8;

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [BUF_W-1:0]  buf_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              ending_n;
    logic              ended_n;
    logic [DROP_W-1:0] drop_n;

    assign atom_ready = (state == ACCUM);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ACCUM;
            dct_buffer     <= '0;
            dct_count      <= '0;
            frame_valid    <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
            dropped_atoms  <= '0;
        end else begin
            state          <= state_n;
            dct_buffer     <= buf_n;
            dct_count      <= cnt_n;
            frame_valid    <= (state_n == FLUSH);
            test_ending    <= ending_n;
            test_has_ended <= ended_n;
            dropped_atoms  <= drop_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n  = state;
        buf_n    = dct_buffer;
        cnt_n    = dct_count;
        ending_n = test_ending;
        ended_n  = test_has_ended;
        drop_n   = dropped_atoms;

        if (atom_valid && !atom_ready && (dropped_atoms != '1)) begin
            drop_n = dropped_atoms + DROP_W'(1);
        end

        case (state)
            ACCUM: begin
                if (atom_valid) begin
                    buf_n = dct_buffer | (BUF_W'(atom_data) << {dct_count, 1'b0});
                    cnt_n = dct_count + CNT_W'(1);
                end
                if (end_req) begin
                    ending_n = 1'b1;
                end
                // A full frame always flushes; end_req then closes after its handoff
                if (cnt_n == CNT_W'(MAX_ATOMS)) begin
                    state_n = FLUSH;
                end else if (end_req) begin
                    if (cnt_n != '0) begin
                        state_n = FLUSH;
                    end else begin
                        state_n = DONE;
                        ended_n = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (end_req) begin
                    ending_n = 1'b1;
                end
                if (frame_ready) begin
                    buf_n = '0;
                    cnt_n = '0;
                    if (ending_n) begin
                        state_n = DONE;
                        ended_n = 1'b1;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_core7_cpu_3_nios2_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_core7_cpu_3_nios2_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        atom_ready;
    logic        end_req;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic        test_ending;
    logic        test_has_ended;
    logic [7:0]  dropped_atoms;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending atoms, frame-held flag, sticky end flags
    int q[$];
    bit m_pending;
    bit m_ending;
    bit m_ended;
    int m_dropped;

    core7_cpu_3_nios2_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .atom_ready     (atom_ready),
        .end_req        (end_req),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frame_valid    (frame_valid),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .dropped_atoms  (dropped_atoms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !m_pending && !m_ended;
    endfunction

    function automatic logic [31:0] model_buf();
        logic [31:0] b = 32'd0;
        foreach (q[i]) b = b + (32'(q[i]) << (2 * i));
        return b;
    endfunction

    task automatic model_clear();
        q.delete();
        m_pending = 0;
        m_ending  = 0;
        m_ended   = 0;
        m_dropped = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit e, input bit fr);
        if (v && !model_ready() && m_dropped < 255) m_dropped++;
        if (model_ready()) begin
            if (v) q.push_back(d);
            if (e) m_ending = 1;
            if (q.size() == 15) m_pending = 1;
            else if (e) begin
                if (q.size() > 0) m_pending = 1;
                else m_ended = 1;
            end
        end else if (m_pending) begin
            if (e) m_ending = 1;
            if (fr) begin
                q.delete();
                m_pending = 0;
                if (m_ending) m_ended = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("dct_buffer", 32'(dct_buffer), model_buf());
        check("dct_count", 32'(dct_count), 32'(q.size()));
        check("frame_valid", 32'(frame_valid), 32'(m_pending));
        check("test_ending", 32'(test_ending), 32'(m_ending));
        check("test_has_ended", 32'(test_has_ended), 32'(m_ended));
        check("dropped_atoms", 32'(dropped_atoms), 32'(m_dropped));
        check("atom_ready", 32'(atom_ready), 32'(model_ready()));
    endtask

    // One clock: drive at negedge, check combinational ready, step model on posedge
    task automatic step(input bit v, input bit [1:0] d, input bit e, input bit fr);
        @(negedge clk);
        atom_valid  = v;
        atom_data   = d;
        end_req     = e;
        frame_ready = fr;
        #1 check("atom_ready_pre", 32'(atom_ready), 32'(model_ready()));
        @(posedge clk);
        model_step(v, int'(d), e, fr);
        #1 compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buf"}, 32'(dct_buffer), 32'd0);
        check({tag, "_cnt"}, 32'(dct_count), 32'd0);
        check({tag, "_fv"}, 32'(frame_valid), 32'd0);
        check({tag, "_te"}, 32'(test_ending), 32'd0);
        check({tag, "_the"}, 32'(test_has_ended), 32'd0);
        check({tag, "_drop"}, 32'(dropped_atoms), 32'd0);
        check({tag, "_ready"}, 32'(atom_ready), 32'd1);
    endtask

    // Asynchronous assert away from any edge, synchronous-ish release at negedge
    task automatic apply_reset(input string tag);
        @(negedge clk);
        atom_valid  = 1'b0;
        end_req     = 1'b0;
        frame_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_all_zero(tag);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_all_zero({tag, "_rel"});
    endtask

    initial begin
        reset_n     = 1'b0;
        atom_valid  = 1'b0;
        atom_data   = 2'd0;
        end_req     = 1'b0;
        frame_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Full frame of i%4
        for (int i = 0; i < 15; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b1);
        check("full_buf", 32'(dct_buffer), 32'h24E4E4E4);
        check("full_cnt", 32'(dct_count), 32'd15);
        check("full_fv", 32'(frame_valid), 32'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("full_clr_cnt", 32'(dct_count), 32'd0);
        check("full_clr_fv", 32'(frame_valid), 32'd0);

        // Backpressure with atoms offered while the frame is held
        for (int i = 0; i < 15; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0);
        check("bp_drop", 32'(dropped_atoms), 32'd10);
        check("bp_ready", 32'(atom_ready), 32'd0);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("bp_clr_ready", 32'(atom_ready), 32'd1);

        // Partial flush at end of test
        for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("part_buf", 32'(dct_buffer), 32'h3F);
        check("part_cnt", 32'(dct_count), 32'd3);
        check("part_te", 32'(test_ending), 32'd1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("part_the", 32'(test_has_ended), 32'd1);
        step(1'b0, 2'd0, 1'b1, 1'b1);

        // Empty end, then drop counter saturation in DONE
        apply_reset("rst_a");
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("empty_te", 32'(test_ending), 32'd1);
        check("empty_the", 32'(test_has_ended), 32'd1);
        check("empty_fv", 32'(frame_valid), 32'd0);
        for (int i = 0; i < 300; i++) step(1'b1, 2'd1, 1'b0, 1'b1);
        check("sat_drop", 32'(dropped_atoms), 32'hFF);

        // Reset while a frame is held
        apply_reset("rst_b");
        for (int i = 0; i < 15; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        apply_reset("midflush");
        step(1'b1, 2'd2, 1'b0, 1'b0);
        check("resume_cnt", 32'(dct_count), 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (m_ended && $urandom_range(0, 9) == 0) apply_reset("rst_rand");
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
